// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one ALU/multiplier datapath between NREQ requesters.
// One operation in flight at a time; a missing dp_done is aborted after TIMEOUT cycles.
module alu_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 dp_start,
    output logic [3:0]           dp_op,
    output logic [31:0]          dp_a,
    output logic [31:0]          dp_b,
    input  logic                 dp_done,
    input  logic [63:0]          dp_result,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int IW        = 3;
    localparam int SLOTS     = 8;
    localparam int TO_LAST_I = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
    // Counter value seen in the final WAIT cycle; RESP then lands TIMEOUT cycles after dp_start.
    localparam logic [CW:0] TO_LAST = TO_LAST_I[CW:0];

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_reg;
    logic [IW-1:0]     last_reg;
    logic [IW-1:0]     grant_reg;
    logic [CW-1:0]     cnt_reg;
    logic              dp_start_reg;
    logic [3:0]        dp_op_reg;
    logic [31:0]       dp_a_reg;
    logic [31:0]       dp_b_reg;
    logic [NREQ-1:0]   rsp_valid_reg;
    logic [63:0]       rsp_data_reg;
    logic              rsp_err_reg;

    logic [3:0]        op_arr [SLOTS];
    logic [31:0]       a_arr  [SLOTS];
    logic [31:0]       b_arr  [SLOTS];
    logic [NREQ-1:0]   grant_oh;

    logic [IW-1:0]     ptr;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     off;
    logic [IW:0]       sum;
    logic              win_any;
    logic [IW-1:0]     win_idx;
    logic              rsp_fire;

    // Unpack the flat request buses; padding slots keep the 3-bit grant index in range.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NREQ) begin : g_used
                assign op_arr[gi] = req_op[gi*4 +: 4];
                assign a_arr[gi]  = req_a[gi*32 +: 32];
                assign b_arr[gi]  = req_b[gi*32 +: 32];
            end else begin : g_pad
                assign op_arr[gi] = '0;
                assign a_arr[gi]  = '0;
                assign b_arr[gi]  = '0;
            end
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_ready[gi] = (state_reg == IDLE) && win_any && (win_idx == IW'(gi));
            assign grant_oh[gi]  = (grant_reg == IW'(gi));
        end
    endgenerate

    // Rotate the valid vector so bit 0 is the requester just after the last grant.
    assign ptr = (last_reg == IW'(NREQ - 1)) ? '0 : last_reg + IW'(1);
    assign rot = NREQ'({req_valid, req_valid} >> ptr);

    always_comb begin
        win_any = 1'b0;
        off     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win_any = 1'b1;
                off     = IW'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
        end
        win_idx = sum[IW-1:0];
    end

    assign rsp_fire = |(rsp_ready & rsp_valid_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            last_reg      <= IW'(NREQ - 1);
            grant_reg     <= '0;
            cnt_reg       <= '0;
            dp_start_reg  <= 1'b0;
            dp_op_reg     <= '0;
            dp_a_reg      <= '0;
            dp_b_reg      <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            dp_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        dp_op_reg    <= op_arr[win_idx];
                        dp_a_reg     <= a_arr[win_idx];
                        dp_b_reg     <= b_arr[win_idx];
                        grant_reg    <= win_idx;
                        dp_start_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A done in the final cycle still beats the timeout.
                    if (dp_done) begin
                        rsp_data_reg  <= dp_result;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= grant_oh;
                        state_reg     <= RESP;
                    end else if ({1'b0, cnt_reg} >= TO_LAST) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= grant_oh;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_fire) begin
                        last_reg      <= grant_reg;
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign grant_id  = grant_reg;
    assign dp_start  = dp_start_reg;
    assign dp_op     = dp_op_reg;
    assign dp_a      = dp_a_reg;
    assign dp_b      = dp_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: a transaction-level timing model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_req_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 255;
    localparam int CW      = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [4*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [63:0]         rsp_data;
    logic                rsp_err;
    logic                dp_start;
    logic [3:0]          dp_op;
    logic [31:0]         dp_a, dp_b;
    logic                dp_done;
    logic [63:0]         dp_result;
    logic                busy;
    logic [2:0]          grant_id;

    always #5 clk = ~clk;

    alu_req_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dp_start(dp_start), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
        .dp_done(dp_done), .dp_result(dp_result),
        .busy(busy), .grant_id(grant_id)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Stimulus driven at the next step
    logic            tb_reset_n = 1'b0;
    logic [NREQ-1:0] tb_valid = '0;
    logic [NREQ-1:0] tb_rsp_ready = '0;
    logic [3:0]      tb_op [NREQ];
    logic [31:0]     tb_a  [NREQ];
    logic [31:0]     tb_b  [NREQ];
    int              next_delay = 1;   // 0 = datapath never answers
    bit              tb_spurious = 0;
    bit              auto_drop = 1;

    // Transaction-level model: an op accepted at cycle A starts at A+1 and
    // responds at A+1+min(d+1, TIMEOUT), where d is the done delay after start.
    bit          m_known = 0;
    bit          m_idle = 1;
    int          m_last = NREQ - 1;
    int          m_grant = 0;
    int          m_acc = -10;
    int          m_delay = 0;
    int          m_rsp_start = 0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [63:0] m_res, m_data;
    bit          m_err;

    function automatic logic [63:0] dp_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'h5:    return {32'b0, a} + {32'b0, b};
            4'h8:    return {32'b0, a} * {32'b0, b};
            default: return {a, b} ^ {60'b0, op};
        endcase
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic compare();
        logic [NREQ-1:0] exp_ready, exp_rspv;
        int p;
        exp_ready = '0;
        exp_rspv  = '0;
        p = m_idle ? rr_pick(tb_valid, m_last) : -1;
        if (p >= 0) exp_ready[p] = 1'b1;
        if (!m_idle && cyc >= m_rsp_start) exp_rspv[m_grant] = 1'b1;
        chk("busy", busy, !m_idle);
        chk("req_ready", req_ready, exp_ready);
        chk("dp_start", dp_start, !m_idle && cyc == m_acc + 1);
        chk("rsp_valid", rsp_valid, exp_rspv);
        chk("grant_id", grant_id, m_grant);
        if (!m_idle && cyc > m_acc && cyc < m_rsp_start) begin
            chk("dp_op", dp_op, m_op);
            chk("dp_a", dp_a, m_a);
            chk("dp_b", dp_b, m_b);
        end
        if (exp_rspv != '0) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", rsp_err, m_err);
        end
    endtask

    task automatic model_advance();
        int p;
        if (!tb_reset_n) begin
            m_known = 1;
            m_idle  = 1;
            m_last  = NREQ - 1;
            m_grant = 0;
        end else if (m_idle) begin
            p = rr_pick(tb_valid, m_last);
            if (p >= 0) begin
                m_idle  = 0;
                m_grant = p;
                m_acc   = cyc;
                m_delay = next_delay;
                m_op    = tb_op[p];
                m_a     = tb_a[p];
                m_b     = tb_b[p];
                m_res   = dp_fn(m_op, m_a, m_b);
                if (m_delay != 0 && m_delay <= TIMEOUT - 1) begin
                    m_rsp_start = cyc + 2 + m_delay;
                    m_data = m_res;
                    m_err  = 0;
                end else begin
                    m_rsp_start = cyc + 1 + TIMEOUT;
                    m_data = '0;
                    m_err  = 1;
                end
                $display("txn cyc=%0d req=%0d op=%h a=%h b=%h delay=%0d exp_err=%0d exp_data=%h",
                         cyc, p, m_op, m_a, m_b, m_delay, m_err, m_data);
                if (auto_drop) tb_valid[p] = 1'b0;
            end
        end else if (cyc >= m_rsp_start && tb_rsp_ready[m_grant]) begin
            m_last = m_grant;
            m_idle = 1;
        end
    endtask

    task automatic step();
        bit sched_done, spur_ok;
        @(negedge clk);
        reset_n   = tb_reset_n;
        req_valid = tb_valid;
        rsp_ready = tb_rsp_ready;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i*4 +: 4]  = tb_op[i];
            req_a[i*32 +: 32] = tb_a[i];
            req_b[i*32 +: 32] = tb_b[i];
        end
        sched_done = !m_idle && m_delay != 0 && cyc == m_acc + 1 + m_delay;
        spur_ok    = m_idle || cyc == m_acc + 1 || cyc >= m_rsp_start;
        dp_done    = sched_done || (tb_spurious && spur_ok);
        dp_result  = sched_done ? m_res : {$urandom, $urandom};
        #1;
        if (m_known) compare();
        model_advance();
        cyc++;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        tb_op[i] = op;
        tb_a[i]  = a;
        tb_b[i]  = b;
    endtask

    task automatic do_reset();
        tb_reset_n = 1'b0;
        step();
        tb_reset_n = 1'b1;
    endtask

    task automatic wait_rsp(input string name, input int bound);
        int k = 0;
        while (rsp_valid == '0 && k < bound) begin
            step();
            k++;
        end
        chk(name, rsp_valid != '0, 1'b1);
    endtask

    task automatic wait_ready(input string name, input int bound);
        int k = 0;
        while (req_ready == '0 && k < bound) begin
            step();
            k++;
        end
        chk(name, req_ready != '0, 1'b1);
    endtask

    task automatic finish_txn();
        int k = 0;
        tb_rsp_ready = '1;
        while (!m_idle && k < 600) begin
            step();
            k++;
        end
        tb_rsp_ready = '0;
        step();
        chk("idle_after_rsp", busy, 1'b0);
    endtask

    logic [31:0] a_tab [NREQ] = '{32'h0000_0003, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b_tab [NREQ] = '{32'h0000_0005, 32'h0001_0000, 32'h0000_0004, 32'hFFFF_FFFF};
    logic [63:0] prod_tab [NREQ] = '{64'd15, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000,
                                     64'hFFFF_FFFE_0000_0001};
    int order_tab [5] = '{0, 1, 2, 3, 0};

    initial begin
        int k;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'h0, 32'h0, 32'h0);
        do_reset();
        step();

        // 1: single request from requester 2
        set_req(2, 4'h5, 32'hFFFF_FFFF, 32'h1);
        next_delay = 3;
        tb_valid = 4'b0100;
        step();
        chk("t1_req_ready", req_ready, 4'b0100);
        chk("t1_no_start_yet", dp_start, 1'b0);
        step();
        chk("t1_dp_start", dp_start, 1'b1);
        chk("t1_dp_op", dp_op, 4'h5);
        chk("t1_ready_one_cycle", req_ready, 4'b0000);
        k = 0;
        while (rsp_valid == '0 && k < 20) begin step(); k++; end
        chk("t1_latency", k, 4);
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_data", rsp_data, 64'h0000_0001_0000_0000);
        chk("t1_rsp_err", rsp_err, 1'b0);
        tb_rsp_ready = 4'b0100;
        step();
        tb_rsp_ready = '0;
        step();
        chk("t1_busy_after", busy, 1'b0);

        // 2: round robin with every requester continuously valid
        do_reset();
        auto_drop = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'h8, a_tab[i], b_tab[i]);
        next_delay = 1;
        tb_rsp_ready = '1;
        tb_valid = '1;
        for (int t = 0; t < 5; t++) begin
            int g;
            logic [NREQ-1:0] oh;
            g = order_tab[t];
            oh = '0;
            oh[g] = 1'b1;
            wait_ready("t2_ready_seen", 20);
            chk("t2_grant_order", req_ready, oh);
            step();
            chk("t2_grant_id", grant_id, g);
            wait_rsp("t2_rsp_seen", 20);
            chk("t2_product", rsp_data, prod_tab[g]);
        end
        tb_valid = '0;
        auto_drop = 1;
        tb_rsp_ready = '0;
        step();
        step();

        // 3: timeout, then a normal request
        set_req(0, 4'h3, 32'h1234_5678, 32'h9ABC_DEF0);
        next_delay = 0;
        tb_valid = 4'b0001;
        step();
        step();
        chk("t3_dp_start", dp_start, 1'b1);
        k = 0;
        while (rsp_valid == '0 && k < 300) begin step(); k++; end
        chk("t3_latency", k, 255);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_data", rsp_data, 64'h0);
        finish_txn();
        set_req(2, 4'h8, 32'd6, 32'd7);
        next_delay = 2;
        tb_valid = 4'b0100;
        wait_rsp("t3_next_seen", 20);
        chk("t3_next_err", rsp_err, 1'b0);
        chk("t3_next_data", rsp_data, 64'd42);
        finish_txn();

        // 4: done in the final WAIT cycle
        set_req(2, 4'h5, 32'h0000_ABCD, 32'h0);
        next_delay = TIMEOUT - 1;
        tb_valid = 4'b0100;
        step();
        step();
        k = 0;
        while (rsp_valid == '0 && k < 300) begin step(); k++; end
        chk("t4_latency", k, 255);
        chk("t4_rsp_err", rsp_err, 1'b0);
        chk("t4_rsp_data", rsp_data, 64'hABCD);
        finish_txn();

        // 5: response backpressure while requester 1 waits
        set_req(0, 4'h5, 32'd7, 32'd8);
        next_delay = 2;
        tb_valid = 4'b0001;
        wait_rsp("t5_rsp_seen", 20);
        set_req(1, 4'h8, 32'd3, 32'd3);
        tb_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_ready1_low", req_ready[1], 1'b0);
            chk("t5_rsp_valid", rsp_valid, 4'b0001);
            chk("t5_rsp_data", rsp_data, 64'd15);
        end
        tb_rsp_ready = 4'b0001;
        step();
        chk("t5_ready_handshake", req_ready, 4'b0000);
        tb_rsp_ready = '0;
        step();
        chk("t5_ready_after", req_ready, 4'b0010);
        wait_rsp("t5_req1_seen", 20);
        chk("t5_req1_data", rsp_data, 64'd9);
        finish_txn();

        // 6: reset in WAIT, then a stale done
        set_req(1, 4'h2, 32'h5555_AAAA, 32'h0F0F_0F0F);
        next_delay = 0;
        tb_valid = 4'b0010;
        repeat (4) step();
        chk("t6_busy_in_wait", busy, 1'b1);
        tb_reset_n = 1'b0;
        step();
        tb_reset_n = 1'b1;
        tb_valid = '0;
        step();
        chk("t6_req_ready", req_ready, 4'b0);
        chk("t6_rsp_valid", rsp_valid, 4'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_dp_start", dp_start, 1'b0);
        chk("t6_dp_op", dp_op, 4'h0);
        chk("t6_dp_a", dp_a, 32'h0);
        chk("t6_dp_b", dp_b, 32'h0);
        chk("t6_rsp_data", rsp_data, 64'h0);
        chk("t6_rsp_err", rsp_err, 1'b0);
        chk("t6_grant_id", grant_id, 3'd0);
        tb_spurious = 1;
        step();
        tb_spurious = 0;
        step();
        chk("t6_stale_rsp", rsp_valid, 4'b0);
        chk("t6_stale_busy", busy, 1'b0);
        set_req(0, 4'h1, 32'h11, 32'h22);
        set_req(3, 4'h1, 32'h33, 32'h44);
        next_delay = 1;
        tb_valid = 4'b1001;
        step();
        chk("t6_first_grant", req_ready, 4'b0001);
        tb_valid[3] = 1'b0;
        finish_txn();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            for (int i = 0; i < NREQ; i++) begin
                if (!tb_valid[i] && $urandom_range(3) == 0) begin
                    set_req(i, 4'($urandom), $urandom, $urandom);
                    tb_valid[i] = 1'b1;
                end else if (tb_valid[i] && $urandom_range(31) == 0) begin
                    tb_valid[i] = 1'b0;
                end
            end
            tb_rsp_ready = NREQ'($urandom);
            r = $urandom_range(15);
            if (r == 0)      next_delay = 0;
            else if (r == 1) next_delay = 250 + $urandom_range(9);
            else             next_delay = $urandom_range(1, 6);
            tb_spurious = ($urandom_range(7) == 0);
            tb_reset_n  = ($urandom_range(399) != 0);
            step();
        end
        tb_spurious = 0;
        tb_reset_n = 1'b1;
        tb_valid = '0;
        finish_txn();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
